// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback queue.
package wb_pkg;

    localparam int WB_AW    = 5;
    localparam int WB_DW    = 32;
    localparam int WB_DEPTH = 4;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    // Occupancy counter width: must be able to represent DEPTH itself.
    function automatic int wb_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_queue_if.sv
// Producer / register-file / bypass signal bundle for wb_queue.
// Bypass lookup signals exist only when WB_BYPASS_EN is defined.
interface wb_queue_if
    import wb_pkg::*;
#(
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    parameter int DEPTH = WB_DEPTH
);
    localparam int CW = wb_cnt_w(DEPTH);

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          wr_stall;
    logic          RegWrite;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic [CW-1:0] count;
    logic          empty;
`ifdef WB_BYPASS_EN
    logic [AW-1:0] rd_addr_1;
    logic [AW-1:0] rd_addr_2;
    logic          byp_hit_1;
    logic          byp_hit_2;
    logic [DW-1:0] byp_data_1;
    logic [DW-1:0] byp_data_2;
`endif

    modport slave (
        input  in_valid, in_addr, in_data, wr_stall,
        output in_ready, RegWrite, write_address, write_data, count, empty
`ifdef WB_BYPASS_EN
        ,
        input  rd_addr_1, rd_addr_2,
        output byp_hit_1, byp_hit_2, byp_data_1, byp_data_2
`endif
    );

    modport master (
        output in_valid, in_addr, in_data, wr_stall,
        input  in_ready, RegWrite, write_address, write_data, count, empty
`ifdef WB_BYPASS_EN
        ,
        output rd_addr_1, rd_addr_2,
        input  byp_hit_1, byp_hit_2, byp_data_1, byp_data_2
`endif
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular entry store with separate occupancy count; under WB_BYPASS_EN it
// also exposes every slot in age order (slot 0 = oldest) for the bypass search.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int EW    = WB_AW + WB_DW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = wb_cnt_w(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [EW-1:0]       wdata_i,
    output logic [EW-1:0]       rdata_o,
    output logic [CW-1:0]       count_o,
    output logic                full_o,
    output logic                empty_o
`ifdef WB_BYPASS_EN
    ,
    output logic [DEPTH*EW-1:0] entries_o,
    output logic [DEPTH-1:0]    valid_o
`endif
);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(push_i) - CW'(pop_i);
        if (push_i) tail_d = tail_q + 1'b1;
        if (pop_i)  head_d = head_q + 1'b1;
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_i) mem_q[tail_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

`ifdef WB_BYPASS_EN
    always_comb begin
        entries_o = '0;
        valid_o   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            entries_o[k*EW +: EW] = mem_q[head_q + PW'(k)];
            valid_o[k]            = (CW'(k) < count_q);
        end
    end
`endif

endmodule

// File: rtl/wb_queue.sv
// Writeback buffer: in-order queue feeding the register-file write port.
// Optional in-flight operand bypass is enabled by defining WB_BYPASS_EN.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input logic       clk,
    input logic       rst,
    wb_queue_if.slave bus
);

    localparam int CW = wb_cnt_w(DEPTH);
    localparam int EW = AW + DW;

    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [EW-1:0] head_ent;

    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;

`ifdef WB_BYPASS_EN
    logic [DEPTH*EW-1:0] entries;
    logic [DEPTH-1:0]    valid;
`endif

    // Writes to register 0 complete the handshake but never enter the queue.
    assign push = bus.in_valid && !fifo_full && (bus.in_addr != AW'(REG_ZERO));
    assign pop  = !bus.wr_stall && !fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .pop_i     (pop),
        .wdata_i   ({bus.in_addr, bus.in_data}),
        .rdata_o   (head_ent),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
`ifdef WB_BYPASS_EN
        ,
        .entries_o (entries),
        .valid_o   (valid)
`endif
    );

    always_comb begin
        regwrite_d = regwrite_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        if (!bus.wr_stall) begin
            regwrite_d = !fifo_empty;
            if (!fifo_empty) {waddr_d, wdata_d} = head_ent;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.in_ready      = !fifo_full;
    assign bus.RegWrite      = regwrite_q;
    assign bus.write_address = waddr_q;
    assign bus.write_data    = wdata_q;
    assign bus.count         = fifo_count;
    assign bus.empty         = fifo_empty && !regwrite_q;

`ifdef WB_BYPASS_EN
    // Scan oldest to newest so the last match (the newest write) wins.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] ra);
        logic          hit;
        logic [DW-1:0] val;
        logic [EW-1:0] ent;
        hit = 1'b0;
        val = '0;
        if (ra != AW'(REG_ZERO)) begin
            if (regwrite_q && waddr_q == ra) begin
                hit = 1'b1;
                val = wdata_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                ent = entries[k*EW +: EW];
                if (valid[k] && ent[EW-1 -: AW] == ra) begin
                    hit = 1'b1;
                    val = ent[DW-1:0];
                end
            end
        end
        return {hit, val};
    endfunction

    always_comb begin
        {bus.byp_hit_1, bus.byp_data_1} = lookup(bus.rd_addr_1);
        {bus.byp_hit_2, bus.byp_data_2} = lookup(bus.rd_addr_2);
    end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue; bypass scenario runs only when WB_BYPASS_EN is defined.
module tb_wb_queue;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    wb_queue_if #(.AW(5), .DW(32), .DEPTH(4)) bus ();

    wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.wr_stall = 1'b0;
`ifdef WB_BYPASS_EN
        bus.rd_addr_1 = 5'd0;
        bus.rd_addr_2 = 5'd0;
`endif
        #12;
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", bus.RegWrite); end
        checks++; if (bus.write_address !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", bus.write_address); end
        checks++; if (bus.write_data !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.write_data); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
`ifdef WB_BYPASS_EN
        checks++; if (bus.byp_hit_1 !== 1'b0 || bus.byp_data_1 !== 32'd0) begin errors++; $display("FAIL reset_byp1: got %b/%h want 0/0", bus.byp_hit_1, bus.byp_data_1); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bus.in_valid = 1'b1; bus.in_addr = 5'd3; bus.in_data = 32'hDEADBEEF;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.RegWrite !== 1'b0 || bus.count !== 3'd1) begin errors++; $display("FAIL basic_queued: got we=%b cnt=%0d want we=0 cnt=1", bus.RegWrite, bus.count); end
        step();
        checks++; if (bus.RegWrite !== 1'b1 || bus.write_address !== 5'd3 || bus.write_data !== 32'hDEADBEEF)
            begin errors++; $display("FAIL basic_write: got we=%b a=%0d d=%h want 1/3/deadbeef", bus.RegWrite, bus.write_address, bus.write_data); end
        checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b0) begin errors++; $display("FAIL basic_state: got cnt=%0d empty=%b want 0/0", bus.count, bus.empty); end
        step();
        checks++; if (bus.RegWrite !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL basic_done: got we=%b empty=%b want 0/1", bus.RegWrite, bus.empty); end
    endtask

    task automatic test_zero_reg();
        bus.in_valid = 1'b1; bus.in_addr = 5'd0; bus.in_data = 32'h55;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL zero_count: got %0d want 0", bus.count); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL zero_regwrite: got %b want 0", bus.RegWrite); end
            step();
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL zero_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_stall_hold();
        bus.in_valid = 1'b1; bus.in_addr = 5'd10; bus.in_data = 32'hA;
        step();
        bus.in_addr = 5'd11; bus.in_data = 32'hB;
        step();
        bus.in_valid = 1'b0;
        bus.wr_stall = 1'b1;
        checks++; if (bus.RegWrite !== 1'b1 || bus.write_address !== 5'd10 || bus.count !== 3'd1)
            begin errors++; $display("FAIL hold_pre: got we=%b a=%0d cnt=%0d want 1/10/1", bus.RegWrite, bus.write_address, bus.count); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (bus.RegWrite !== 1'b1 || bus.write_address !== 5'd10 || bus.write_data !== 32'hA || bus.count !== 3'd1)
                begin errors++; $display("FAIL hold_stalled: got we=%b a=%0d d=%h cnt=%0d want 1/10/a/1", bus.RegWrite, bus.write_address, bus.write_data, bus.count); end
        end
        bus.wr_stall = 1'b0;
        step();
        checks++; if (bus.RegWrite !== 1'b1 || bus.write_address !== 5'd11 || bus.write_data !== 32'hB || bus.count !== 3'd0)
            begin errors++; $display("FAIL hold_release: got we=%b a=%0d d=%h cnt=%0d want 1/11/b/0", bus.RegWrite, bus.write_address, bus.write_data, bus.count); end
        step();
        checks++; if (bus.RegWrite !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL hold_done: got we=%b empty=%b want 0/1", bus.RegWrite, bus.empty); end
    endtask

    task automatic test_full();
        logic [2:0] exp_cnt [5];
        exp_cnt = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        bus.wr_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1; bus.in_addr = 5'(i); bus.in_data = 32'h100 + 32'(i);
            step();
            checks++; if (bus.count !== 3'(i)) begin errors++; $display("FAIL full_fill%0d: got cnt=%0d want %0d", i, bus.count, i); end
        end
        bus.in_addr = 5'd5; bus.in_data = 32'h105;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", bus.in_ready); end
        step();
        checks++; if (bus.count !== 3'd4 || bus.RegWrite !== 1'b0) begin errors++; $display("FAIL full_blocked: got cnt=%0d we=%b want 4/0", bus.count, bus.RegWrite); end
        bus.wr_stall = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            checks++; if (bus.RegWrite !== 1'b1 || bus.write_address !== 5'(j + 1) || bus.write_data !== 32'h101 + 32'(j) || bus.count !== exp_cnt[j])
                begin errors++; $display("FAIL full_drain%0d: got we=%b a=%0d d=%h cnt=%0d want 1/%0d/%h/%0d", j, bus.RegWrite, bus.write_address, bus.write_data, bus.count, j + 1, 32'h101 + 32'(j), exp_cnt[j]); end
            if (j == 0) begin
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_reready: got %b want 1", bus.in_ready); end
            end
            if (j == 1) bus.in_valid = 1'b0;
        end
        step();
        checks++; if (bus.RegWrite !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL full_done: got we=%b empty=%b want 0/1", bus.RegWrite, bus.empty); end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        bus.wr_stall  = 1'b1;
        bus.rd_addr_1 = 5'd7;
        bus.rd_addr_2 = 5'd0;
        bus.in_valid = 1'b1; bus.in_addr = 5'd7; bus.in_data = 32'h11;
        checks++; if (bus.byp_hit_1 !== 1'b0) begin errors++; $display("FAIL byp_incoming: got %b want 0", bus.byp_hit_1); end
        step();
        checks++; if (bus.byp_hit_1 !== 1'b1 || bus.byp_data_1 !== 32'h11) begin errors++; $display("FAIL byp_first: got %b/%h want 1/11", bus.byp_hit_1, bus.byp_data_1); end
        bus.in_data = 32'h22;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.byp_hit_1 !== 1'b1 || bus.byp_data_1 !== 32'h22) begin errors++; $display("FAIL byp_newest: got %b/%h want 1/22", bus.byp_hit_1, bus.byp_data_1); end
        checks++; if (bus.byp_hit_2 !== 1'b0 || bus.byp_data_2 !== 32'h0) begin errors++; $display("FAIL byp_zero: got %b/%h want 0/0", bus.byp_hit_2, bus.byp_data_2); end
        bus.rd_addr_2 = 5'd9;
        bus.wr_stall  = 1'b0;
        step();
        checks++; if (bus.byp_hit_1 !== 1'b1 || bus.byp_data_1 !== 32'h22 || bus.write_data !== 32'h11) begin errors++; $display("FAIL byp_q_over_out: got %b/%h out=%h want 1/22 out=11", bus.byp_hit_1, bus.byp_data_1, bus.write_data); end
        checks++; if (bus.byp_hit_2 !== 1'b0) begin errors++; $display("FAIL byp_miss: got %b want 0", bus.byp_hit_2); end
        step();
        checks++; if (bus.byp_hit_1 !== 1'b1 || bus.byp_data_1 !== 32'h22) begin errors++; $display("FAIL byp_outreg: got %b/%h want 1/22", bus.byp_hit_1, bus.byp_data_1); end
        step();
        checks++; if (bus.byp_hit_1 !== 1'b0 || bus.byp_data_1 !== 32'h0) begin errors++; $display("FAIL byp_drained: got %b/%h want 0/0", bus.byp_hit_1, bus.byp_data_1); end
        bus.rd_addr_1 = 5'd0;
        bus.rd_addr_2 = 5'd0;
    endtask
`endif

    task automatic test_async_reset();
        bus.wr_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1; bus.in_addr = 5'(i); bus.in_data = 32'(i);
            step();
        end
        bus.in_valid = 1'b0;
        bus.wr_stall = 1'b0;
        step();
        bus.wr_stall = 1'b1;
        checks++; if (bus.RegWrite !== 1'b1 || bus.count !== 3'd3) begin errors++; $display("FAIL areset_pre: got we=%b cnt=%0d want 1/3", bus.RegWrite, bus.count); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.RegWrite !== 1'b0 || bus.count !== 3'd0 || bus.in_ready !== 1'b1 || bus.empty !== 1'b1)
            begin errors++; $display("FAIL areset_now: got we=%b cnt=%0d rdy=%b empty=%b want 0/0/1/1", bus.RegWrite, bus.count, bus.in_ready, bus.empty); end
        #2;
        rst = 1'b0;
        bus.wr_stall = 1'b0;
        step();
        step();
        checks++; if (bus.RegWrite !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL areset_after: got we=%b empty=%b want 0/1", bus.RegWrite, bus.empty); end
    endtask

    task automatic test_back_to_back();
        bus.wr_stall = 1'b0;
        for (int e = 1; e <= 21; e++) begin
            if (e <= 20) begin
                bus.in_valid = 1'b1; bus.in_addr = 5'(e); bus.in_data = 32'(e * 3);
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            if (e >= 2) begin
                checks++; if (bus.RegWrite !== 1'b1 || bus.write_address !== 5'(e - 1) || bus.write_data !== 32'((e - 1) * 3))
                    begin errors++; $display("FAIL b2b_write%0d: got we=%b a=%0d d=%h want 1/%0d/%h", e, bus.RegWrite, bus.write_address, bus.write_data, e - 1, 32'((e - 1) * 3)); end
            end
            checks++; if (bus.count > 3'd1) begin errors++; $display("FAIL b2b_count%0d: got %0d want <=1", e, bus.count); end
        end
        step();
        checks++; if (bus.RegWrite !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL b2b_done: got we=%b empty=%b want 0/1", bus.RegWrite, bus.empty); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_reg();
        test_stall_hold();
        test_full();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
# wb_queue

Register-file writeback buffer that sits between the execute/memory stages and the register file write port. It accepts completed results (destination index plus 32-bit value) over a valid/ready handshake and queues them in order. It drains them one per cycle onto the register file's write signals (write enable, write address, write data), holding off while the register file signals a stall. An optional bypass port lets the operand-read stage fetch values that are still in flight.

## Interface
- `DEPTH`, 4, number of queued writes (power of two, ≥2)
- `AW`, 5, register index width
- `DW`, 32, data width

- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `in_valid` in 1 — producer offers a result
- `in_ready` out 1 — buffer can accept
- `in_addr` in AW — destination register index
- `in_data` in DW — result value
- `wr_stall` in 1 — register file cannot take a write this cycle
- `RegWrite` out 1 — write enable to register file
- `write_address` out AW — register file write index
- `write_data` out DW — register file write value
- `rd_addr_1`, `rd_addr_2` in AW — bypass lookup indices (`WB_BYPASS_EN` only)
- `byp_hit_1`, `byp_hit_2` out 1 — pending write found (`WB_BYPASS_EN` only)
- `byp_data_1`, `byp_data_2` out DW — newest pending value (`WB_BYPASS_EN` only)
- `count` out $clog2(DEPTH)+1 — entries queued, excluding the output register
- `empty` out 1 — queue and output register both idle

## Operation
- Accept: on `in_valid && in_ready`, enqueue {`in_addr`, `in_data`} at the tail.
- Writes with `in_addr == 0` are accepted (handshake completes) but discarded, not enqueued. Register 0 is never written.
- `in_ready = (count < DEPTH)`. This is combinational on state only; it does not depend on a same-cycle pop.
- Output register: holds {`RegWrite`, `write_address`, `write_data`}.
  - Each edge with `wr_stall == 0`: if the queue is non-empty, pop the head into the output register and set `RegWrite = 1`. Otherwise set `RegWrite = 0`.
  - Each edge with `wr_stall == 1`: the output register and queue hold unchanged (no pop), so a pending write stays asserted until taken.
- Each edge with `wr_stall == 0` and `RegWrite == 1` retires the presented write.
- Simultaneous push and pop: both occur and `count` is unchanged. Pushing into an empty queue while popping is not a pass-through; the entry lands in the queue first.
- Order is strict FIFO. Multiple pending writes to the same index all retire in order.
- `empty = (count == 0) && !RegWrite`.

## Timing
- Reset values: `RegWrite = 0`, `write_address = 0`, `write_data = 0`, `count = 0`, `empty = 1`, `in_ready = 1`, `byp_hit_* = 0`, `byp_data_* = 0`. Head and tail pointers are 0.
- Reset asserted mid-operation discards all queued and presented writes immediately (asynchronously). `RegWrite` drops without waiting for a clock edge.
- Latency with no stall: a result accepted at edge N is in the queue after N; it is popped at edge N+1; `RegWrite` is high during cycle N+1…N+2. Minimum latency is 2 edges.
- Full: `count == DEPTH` forces `in_ready = 0`. It reasserts in the cycle after a pop.
- Pointers wrap modulo DEPTH. `count` is maintained separately, so full and empty are unambiguous.
- Sustained throughput is one write per cycle when `wr_stall` is low.

## Configuration
- `WB_BYPASS_EN` defined: the bypass ports exist and are combinational from state and `rd_addr_*`.
  - The search covers the output register (if `RegWrite`) and all valid queue entries.
  - The newest matching entry wins: the queue tail side beats the head, and any queue entry beats the output register.
  - `rd_addr_* == 0` never hits. On a miss, `byp_data_* = 0`.
  - Entries being accepted in the current cycle are not visible.
- `WB_BYPASS_EN` undefined: the bypass ports and search logic are absent. Downstream reads must wait for `empty`.

## Structure
- A shared package `wb_pkg` holds:
  - the `wb_entry_t` typedef {addr[AW], data[DW]};
  - the default constants `WB_AW = 5`, `WB_DW = 32`, `WB_DEPTH = 4`;
  - the `REG_ZERO = 0` constant.
- One sub-module, `wb_fifo`, is natural: storage plus head/tail/count, with push/pop/full/empty and a flat read-out of all entries and valid bits for the bypass search.
- `wb_queue` owns the handshake, the zero-register filter, the output register and the bypass priority logic.

## Test plan
- Reset, then push (addr 3, 0xDEADBEEF) at edge 1 with no stall → `RegWrite = 1`, `write_address = 3`, `write_data = 0xDEADBEEF` for exactly one cycle starting after edge 2; `empty = 1` afterwards.
- Push (addr 0, 0x55) → handshake completes, `count` stays 0, `RegWrite` never rises.
- Hold `wr_stall = 1` and push 5 entries (addrs 1–5) → 4 accepted, `in_ready = 0` with `count = 4`. Release the stall → writes 1, 2, 3, 4 appear on consecutive cycles; entry 5 is accepted once `in_ready` returns and retires last.
- Under `WB_BYPASS_EN`, hold `wr_stall = 1`, then push (7, 0x11) and (7, 0x22), and set `rd_addr_1 = 7`, `rd_addr_2 = 0` → `byp_hit_1 = 1`, `byp_data_1 = 0x22`, `byp_hit_2 = 0`.
- Assert `rst` asynchronously while `RegWrite = 1` and `count = 3` → `RegWrite` falls before the next edge, `count = 0`, `in_ready = 1`.
- Keep `in_valid` high and `wr_stall` low for 20 cycles with incrementing addresses 1–20 → 20 writes retire in order, one per cycle, and `count` never exceeds 1.
